// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper sequencer: coil patterns, drive-mode
// encodings and FSM state encoding.
package stepper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_WAVE = 2'b00;
  localparam logic [1:0] MODE_TWO  = 2'b01;

  // Coil bit order is {A,C,B,D}
  localparam logic [3:0] COIL_A  = 4'b1000;
  localparam logic [3:0] COIL_AB = 4'b1010;
  localparam logic [3:0] COIL_B  = 4'b0010;
  localparam logic [3:0] COIL_BC = 4'b0110;
  localparam logic [3:0] COIL_C  = 4'b0100;
  localparam logic [3:0] COIL_CD = 4'b0101;
  localparam logic [3:0] COIL_D  = 4'b0001;
  localparam logic [3:0] COIL_DA = 4'b1001;

  function automatic logic [3:0] coil_pattern(input logic [2:0] idx);
    logic [3:0] pat;
    case (idx)
      3'd0:    pat = COIL_A;
      3'd1:    pat = COIL_AB;
      3'd2:    pat = COIL_B;
      3'd3:    pat = COIL_BC;
      3'd4:    pat = COIL_C;
      3'd5:    pat = COIL_CD;
      3'd6:    pat = COIL_D;
      default: pat = COIL_DA;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/step_rate_divider.sv
// Step rate divider: latches the step period on load and emits a tick
// every period cycles while enabled (period 0 behaves as 1).
module step_rate_divider
  import stepper_pkg::*;
#(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] reload;
  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] load_val;

  assign load_val = (period == '0) ? '0 : period - DIV_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reload <= '0;
      count  <= '0;
    end else if (load) begin
      reload <= load_val;
      count  <= load_val;
    end else if (en) begin
      count <= (count == '0) ? reload : count - DIV_W'(1);
    end
  end

  assign tick = en && (count == '0);

endmodule

// File: rtl/stepper_seq_ctrl.sv
// 4-coil stepper sequencer: accepts move commands, steps the coil phase index
// at the programmed rate and tracks absolute position in half-step units.
// Optional feature: define IDLE_RELEASE_EN to de-energise coils after
// HOLD_CYCLES consecutive idle cycles.
//
// state   | meaning
// ST_IDLE | waiting for a command, cmd_ready high
// ST_RUN  | stepping; divider running
// ST_DONE | one-cycle done pulse after a completed move
module stepper_seq_ctrl
  import stepper_pkg::*;
#(
  parameter int STEP_W      = 16,
  parameter int DIV_W       = 24,
  parameter int POS_W       = 32,
  parameter int HOLD_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_dir,
  input  logic [1:0]              cmd_mode,
  input  logic [STEP_W-1:0]       cmd_steps,
  input  logic [DIV_W-1:0]        cmd_period,
  input  logic                    abort,
  output logic [3:0]              coils,
  output logic                    step_pulse,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic signed [POS_W-1:0] position
);

`ifdef IDLE_RELEASE_EN
  localparam bit RELEASE_EN = 1'b1;
`else
  localparam bit RELEASE_EN = 1'b0;
`endif
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 2);

  state_t                    state, state_nx;
  logic [2:0]                idx, idx_nx, delta;
  logic signed [POS_W-1:0]   pos;
  logic [STEP_W-1:0]         remaining;
  logic                      dir_q;
  logic [1:0]                mode_q;
  logic                      accept, tick, step, pulse_q, double_step;
  logic [HOLD_W-1:0]         idle_cnt;
  logic                      released;

  step_rate_divider #(.DIV_W(DIV_W)) u_div (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .en     (state == ST_RUN),
    .period (cmd_period),
    .tick   (tick)
  );

  always_comb begin
    accept      = (state == ST_IDLE) && cmd_valid;
    step        = (state == ST_RUN) && tick && !abort;
    double_step = 1'b0;
    // Wave sits on even indices, two-coil on odd; off-parity steps realign by one
    if (mode_q == MODE_WAVE)
      double_step = !idx[0];
    else if (mode_q == MODE_TWO)
      double_step = idx[0];
    delta  = double_step ? 3'd2 : 3'd1;
    idx_nx = dir_q ? idx + delta : idx - delta;

    state_nx = state;
    case (state)
      ST_IDLE: if (cmd_valid) state_nx = (cmd_steps == '0) ? ST_DONE : ST_RUN;
      ST_RUN: begin
        if (abort)
          state_nx = ST_IDLE;
        else if (step && remaining == STEP_W'(1))
          state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      pos       <= '0;
      remaining <= '0;
      dir_q     <= 1'b0;
      mode_q    <= MODE_WAVE;
      pulse_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      pulse_q <= step;
      if (accept) begin
        dir_q     <= cmd_dir;
        mode_q    <= cmd_mode;
        remaining <= cmd_steps;
      end
      if (step) begin
        idx       <= idx_nx;
        pos       <= dir_q ? pos + POS_W'(delta) : pos - POS_W'(delta);
        remaining <= remaining - STEP_W'(1);
      end
    end
  end

  // Cleared on accept so the coils re-energise as cmd_ready drops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      idle_cnt <= '0;
    else if (state != ST_IDLE || accept)
      idle_cnt <= '0;
    else if (idle_cnt != HOLD_W'(HOLD_CYCLES))
      idle_cnt <= idle_cnt + HOLD_W'(1);
  end

  assign released   = RELEASE_EN && (idle_cnt == HOLD_W'(HOLD_CYCLES));
  assign coils      = released ? 4'b0000 : coil_pattern(idx);
  assign cmd_ready  = (state == ST_IDLE);
  assign busy       = (state == ST_RUN) || (state == ST_DONE);
  assign done       = (state == ST_DONE);
  assign aborted    = (state == ST_RUN) && abort;
  assign step_pulse = pulse_q;
  assign position   = pos;

endmodule

// File: tb/tb_stepper_seq_ctrl.sv
// Directed bench for stepper_seq_ctrl: table of chained moves plus hand-written
// abort, reset and idle-release sequences.
module tb_stepper_seq_ctrl;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_valid, cmd_ready, cmd_dir;
  logic [1:0]         cmd_mode;
  logic [15:0]        cmd_steps;
  logic [23:0]        cmd_period;
  logic               abort;
  logic [3:0]         coils;
  logic               step_pulse, busy, done, aborted;
  logic signed [31:0] position;

  int checks = 0;
  int errors = 0;

  stepper_seq_ctrl #(.HOLD_CYCLES(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_mode   (cmd_mode),
    .cmd_steps  (cmd_steps),
    .cmd_period (cmd_period),
    .abort      (abort),
    .coils      (coils),
    .step_pulse (step_pulse),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .position   (position)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dir;
    logic [1:0]  mode;
    logic [15:0] steps;
    logic [23:0] period;
    logic [3:0]  exp_coils;
    int          exp_pos;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_move(input int n, input vec_t v);
    int eff, limit, pulses, first, last, bad_gap, dones, done_c;
    bit fin;
    eff = (v.period == 0) ? 1 : int'(v.period);
    limit = int'(v.steps) * eff + 20;
    pulses = 0; first = -1; last = -1; bad_gap = 0; dones = 0; done_c = -1; fin = 0;
    @(negedge clk);
    cmd_dir = v.dir; cmd_mode = v.mode; cmd_steps = v.steps; cmd_period = v.period;
    cmd_valid = 1'b1;
    check($sformatf("v%0d ready_before", n), cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int c = 0; c < limit && !fin; c++) begin
      @(negedge clk);
      if (c == 0) check($sformatf("v%0d busy_after_accept", n), busy, 1);
      if (step_pulse) begin
        if (first < 0) first = c;
        else if (c - last != eff) bad_gap++;
        last = c;
        pulses++;
      end
      if (done) begin dones++; done_c = c; end
      if (cmd_ready && dones > 0) fin = 1;
    end
    check($sformatf("v%0d finished", n), fin, 1);
    check($sformatf("v%0d step_count", n), pulses, v.steps);
    check($sformatf("v%0d done_count", n), dones, 1);
    check($sformatf("v%0d done_cycle", n), done_c, int'(v.steps) * eff);
    if (v.steps > 0) check($sformatf("v%0d first_step_latency", n), first, eff);
    if (v.steps > 1) check($sformatf("v%0d step_gaps", n), bad_gap, 0);
    check($sformatf("v%0d coils", n), coils, v.exp_coils);
    check($sformatf("v%0d position", n), position, v.exp_pos);
  endtask

  initial begin
    int pulses;
    vecs[0] = '{1'b1, 2'b10, 16'd8, 24'd4, 4'b1000, 8};
    vecs[1] = '{1'b1, 2'b10, 16'd1, 24'd1, 4'b1010, 9};
    vecs[2] = '{1'b0, 2'b00, 16'd2, 24'd2, 4'b0001, 6};
    vecs[3] = '{1'b1, 2'b01, 16'd3, 24'd3, 4'b0110, 11};
    vecs[4] = '{1'b0, 2'b01, 16'd2, 24'd0, 4'b1001, 7};
    vecs[5] = '{1'b1, 2'b00, 16'd4, 24'd2, 4'b0001, 14};
    vecs[6] = '{1'b0, 2'b11, 16'd3, 24'd1, 4'b0110, 11};
    vecs[7] = '{1'b1, 2'b10, 16'd0, 24'd3, 4'b0110, 11};

    rst = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_mode = 2'b00;
    cmd_steps = '0; cmd_period = '0; abort = 1'b0;
    #12;
    check("reset coils", coils, 4'b1000);
    check("reset position", position, 0);
    check("reset busy", busy, 0);
    check("reset cmd_ready", cmd_ready, 1);
    check("reset done", done, 0);
    check("reset aborted", aborted, 0);
    check("reset step_pulse", step_pulse, 0);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 8; i++) run_move(i, vecs[i]);

    // Abort coincident with the third divider tick
    @(negedge clk);
    cmd_dir = 1'b1; cmd_mode = 2'b10; cmd_steps = 16'd10; cmd_period = 24'd5; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (step_pulse) pulses++;
    end
    abort = 1'b1;
    #1 check("abort aborted_pulse", aborted, 1);
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort step_pulse", step_pulse, 0);
    check("abort step_count", pulses, 2);
    check("abort cmd_ready", cmd_ready, 1);
    check("abort busy", busy, 0);
    check("abort aborted_cleared", aborted, 0);
    check("abort position", position, 13);
    check("abort coils", coils, 4'b0101);

    abort = 1'b1;
    #1 check("idle abort ignored", aborted, 0);
    check("idle abort ready", cmd_ready, 1);
    abort = 1'b0;

    // cmd_valid held with changed inputs during RUN, then async reset
    @(negedge clk);
    cmd_dir = 1'b1; cmd_mode = 2'b10; cmd_steps = 16'd20; cmd_period = 24'd2; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_steps = 16'd1; cmd_dir = 1'b0;
    for (int c = 0; c < 8; c++) @(negedge clk);
    check("held_valid cmd_ready", cmd_ready, 0);
    check("held_valid position", position, 16);
    #2 rst = 1'b0;
    #1;
    check("async_rst coils", coils, 4'b1000);
    check("async_rst position", position, 0);
    check("async_rst busy", busy, 0);
    check("async_rst cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b0;
    @(negedge clk) rst = 1'b1;

    // Idle coil release
    for (int c = 0; c < 3; c++) @(negedge clk);
    check("idle early coils", coils, 4'b1000);
    for (int c = 0; c < 10; c++) @(negedge clk);
`ifdef IDLE_RELEASE_EN
    check("idle released coils", coils, 4'b0000);
`else
    check("idle held coils", coils, 4'b1000);
`endif
    cmd_dir = 1'b1; cmd_mode = 2'b10; cmd_steps = 16'd1; cmd_period = 24'd3; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("reenergise cmd_ready", cmd_ready, 0);
    check("reenergise coils", coils, 4'b1000);
    for (int c = 0; c < 6; c++) @(negedge clk);
    check("reenergise position", position, 1);
    check("reenergise final coils", coils, 4'b1010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
